// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: shares one memory port between the pipeline MEM stage and an
// external word-only requester, with a fairness limit for the external side and an access timeout.
module dmem_arbiter #(
    parameter int unsigned EXT_MAX_WAIT = 4,
    parameter int unsigned TIMEOUT      = 15
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        p_req,
    input  logic        p_we,
    input  logic [31:0] p_addr,
    input  logic [31:0] p_wdata,
    input  logic [1:0]  p_sc,
    input  logic [2:0]  p_lc,
    output logic        p_stall,
    output logic        p_done,
    output logic [31:0] p_rdata,

    input  logic        e_req,
    input  logic        e_we,
    input  logic [31:0] e_addr,
    input  logic [31:0] e_wdata,
    output logic        e_grant,
    output logic        e_done,
    output logic [31:0] e_rdata,

    output logic        m_cs,
    output logic        m_w,
    output logic        m_r,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [1:0]  m_sc,
    output logic [2:0]  m_lc,
    input  logic [31:0] m_rdata,
    input  logic        m_ready,

    output logic        busy,
    output logic        err
);

    localparam int unsigned WinW = (EXT_MAX_WAIT > 0) ? $clog2(EXT_MAX_WAIT + 1) : 1;
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WinW-1:0] WinMax  = WinW'(EXT_MAX_WAIT);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StPAcc,
        StEAcc,
        StPDone,
        StEDone
    } state_e;

    state_e          state_q;
    logic [WinW-1:0] win_cnt_q;
    logic [CntW-1:0] cyc_cnt_q;
    logic            ext_wins;

    // The external side only beats a pending pipeline request once it has waited its quota.
    always_comb begin
        ext_wins = e_req && (!p_req || (win_cnt_q == WinMax));
    end

    assign p_stall = p_req && !p_done;

    // The m_* registers double as the latched request of the access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            win_cnt_q <= '0;
            cyc_cnt_q <= '0;
            err       <= 1'b0;
            p_rdata   <= '0;
            e_rdata   <= '0;
            p_done    <= 1'b0;
            e_done    <= 1'b0;
            e_grant   <= 1'b0;
            busy      <= 1'b0;
            m_cs      <= 1'b0;
            m_w       <= 1'b0;
            m_r       <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
            m_sc      <= '0;
            m_lc      <= '0;
        end else begin
            p_done <= 1'b0;
            e_done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (ext_wins) begin
                        state_q   <= StEAcc;
                        busy      <= 1'b1;
                        e_grant   <= 1'b1;
                        win_cnt_q <= '0;
                        cyc_cnt_q <= '0;
                        m_cs      <= 1'b1;
                        m_w       <= e_we;
                        m_r       <= !e_we;
                        m_addr    <= e_addr;
                        m_wdata   <= e_we ? e_wdata : '0;
                        m_sc      <= '0;
                        m_lc      <= '0;
                    end else if (p_req) begin
                        state_q   <= StPAcc;
                        busy      <= 1'b1;
                        cyc_cnt_q <= '0;
                        m_cs      <= 1'b1;
                        m_w       <= p_we;
                        m_r       <= !p_we;
                        m_addr    <= p_addr;
                        m_wdata   <= p_we ? p_wdata : '0;
                        m_sc      <= p_sc;
                        m_lc      <= p_lc;
                        // Cannot be saturated here, otherwise ext_wins would have been set.
                        if (e_req) begin
                            win_cnt_q <= win_cnt_q + 1'b1;
                        end
                    end
                end
                StPAcc, StEAcc: begin
                    if (m_ready || (cyc_cnt_q == CntLast)) begin
                        state_q <= (state_q == StPAcc) ? StPDone : StEDone;
                        p_done  <= (state_q == StPAcc);
                        e_done  <= (state_q == StEAcc);
                        m_cs    <= 1'b0;
                        m_w     <= 1'b0;
                        m_r     <= 1'b0;
                        m_addr  <= '0;
                        m_wdata <= '0;
                        m_sc    <= '0;
                        m_lc    <= '0;
                        if (m_ready) begin
                            if (m_r && (state_q == StPAcc)) p_rdata <= m_rdata;
                            if (m_r && (state_q == StEAcc)) e_rdata <= m_rdata;
                        end else begin
                            err <= 1'b1;
                            if (state_q == StPAcc) p_rdata <= '0;
                            else                   e_rdata <= '0;
                        end
                    end else begin
                        cyc_cnt_q <= cyc_cnt_q + 1'b1;
                    end
                end
                StPDone, StEDone: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    e_grant <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic, all checked every cycle
// against a transaction-level model of the arbiter.
module tb_dmem_arbiter;

    localparam int unsigned EXT_MAX_WAIT = 4;
    localparam int unsigned TIMEOUT      = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        p_req, p_we, p_stall, p_done;
    logic [31:0] p_addr, p_wdata, p_rdata;
    logic [1:0]  p_sc;
    logic [2:0]  p_lc;
    logic        e_req, e_we, e_grant, e_done;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic        m_cs, m_w, m_r, m_ready;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [1:0]  m_sc;
    logic [2:0]  m_lc;
    logic        busy, err;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .EXT_MAX_WAIT(EXT_MAX_WAIT),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk    (clk),     .reset  (reset),
        .p_req  (p_req),   .p_we   (p_we),    .p_addr (p_addr),  .p_wdata(p_wdata),
        .p_sc   (p_sc),    .p_lc   (p_lc),    .p_stall(p_stall), .p_done (p_done),
        .p_rdata(p_rdata),
        .e_req  (e_req),   .e_we   (e_we),    .e_addr (e_addr),  .e_wdata(e_wdata),
        .e_grant(e_grant), .e_done (e_done),  .e_rdata(e_rdata),
        .m_cs   (m_cs),    .m_w    (m_w),     .m_r    (m_r),     .m_addr (m_addr),
        .m_wdata(m_wdata), .m_sc   (m_sc),    .m_lc   (m_lc),    .m_rdata(m_rdata),
        .m_ready(m_ready), .busy   (busy),    .err    (err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level model: one access record plus fairness and error bookkeeping.
    bit          md_active, md_ext, md_finish, md_we, md_err;
    logic [31:0] md_addr, md_wdata, md_prdata, md_erdata;
    logic [1:0]  md_sc;
    logic [2:0]  md_lc;
    int          md_age, md_streak;

    function automatic bit exp_p_done();
        return md_active && md_finish && !md_ext;
    endfunction

    function automatic bit exp_e_done();
        return md_active && md_finish && md_ext;
    endfunction

    task automatic model_check();
        bit acc;
        acc = md_active && !md_finish;
        check_eq("m_cs",    m_cs,    acc);
        check_eq("m_w",     m_w,     acc && md_we);
        check_eq("m_r",     m_r,     acc && !md_we);
        check_eq("m_addr",  m_addr,  acc ? md_addr : 32'h0);
        check_eq("m_wdata", m_wdata, (acc && md_we) ? md_wdata : 32'h0);
        check_eq("m_sc",    m_sc,    acc ? md_sc : 2'd0);
        check_eq("m_lc",    m_lc,    acc ? md_lc : 3'd0);
        check_eq("p_done",  p_done,  exp_p_done());
        check_eq("e_done",  e_done,  exp_e_done());
        check_eq("e_grant", e_grant, md_active && md_ext);
        check_eq("busy",    busy,    md_active);
        check_eq("p_stall", p_stall, p_req && !exp_p_done());
        check_eq("err",     err,     md_err);
        check_eq("p_rdata", p_rdata, md_prdata);
        check_eq("e_rdata", e_rdata, md_erdata);
    endtask

    task automatic model_step();
        if (reset) begin
            md_active = 0; md_finish = 0; md_streak = 0; md_err = 0;
            md_prdata = '0; md_erdata = '0;
        end else if (!md_active) begin
            if (p_req || e_req) begin
                md_active = 1; md_finish = 0; md_age = 0;
                md_ext = e_req && (!p_req || md_streak == int'(EXT_MAX_WAIT));
                if (md_ext) begin
                    md_we = e_we; md_addr = e_addr; md_wdata = e_wdata;
                    md_sc = 2'd0; md_lc = 3'd0; md_streak = 0;
                end else begin
                    md_we = p_we; md_addr = p_addr; md_wdata = p_wdata;
                    md_sc = p_sc; md_lc = p_lc;
                    if (e_req && md_streak < int'(EXT_MAX_WAIT)) md_streak++;
                end
            end
        end else if (!md_finish) begin
            md_age++;
            if (m_ready) begin
                md_finish = 1;
                if (!md_we) begin
                    if (md_ext) md_erdata = m_rdata;
                    else        md_prdata = m_rdata;
                end
            end else if (md_age == int'(TIMEOUT)) begin
                md_finish = 1;
                md_err    = 1;
                if (md_ext) md_erdata = '0;
                else        md_prdata = '0;
            end
        end else begin
            md_active = 0;
        end
    endtask

    // Inputs are set before calling; outputs checked, model advanced, then one clock passes.
    task automatic tick(input bit chk);
        #1;
        if (chk) model_check();
        model_step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input bit chk);
        reset = 1; p_req = 0; e_req = 0; m_ready = 0;
        tick(chk);
        reset = 0;
    endtask

    int  cnt, pcount, ecount, pct;
    bit  seen, p_pend, e_pend, pd, ed;

    initial begin
        reset = 1; p_req = 0; p_we = 0; p_addr = '0; p_wdata = '0; p_sc = '0; p_lc = '0;
        e_req = 0; e_we = 0; e_addr = '0; e_wdata = '0; m_rdata = '0; m_ready = 0;
        tick(0);
        do_reset(1);
        tick(1);

        // Pipeline read, ready two cycles after select.
        p_req = 1; p_we = 0; p_addr = 32'h40; p_sc = 2'd0; p_lc = 3'd2;
        tick(1);
        check_eq("r27_cs1", m_cs, 1);
        tick(1);
        check_eq("r27_cs2", m_cs, 1);
        tick(1);
        check_eq("r27_cs3", m_cs, 1);
        m_ready = 1; m_rdata = 32'h1234;
        tick(1);
        m_ready = 0;
        check_eq("r27_done",  p_done,  1);
        check_eq("r27_stall", p_stall, 0);
        check_eq("r27_rdata", p_rdata, 32'h1234);
        tick(1);
        p_req = 0;
        tick(1);

        // Pipeline write must not disturb p_rdata.
        p_req = 1; p_we = 1; p_addr = 32'h80; p_wdata = 32'hA5A5A5A5; p_sc = 2'd1;
        tick(1);
        check_eq("r28_w",     m_w,     1);
        check_eq("r28_r",     m_r,     0);
        check_eq("r28_sc",    m_sc,    2'd1);
        check_eq("r28_wdata", m_wdata, 32'hA5A5A5A5);
        check_eq("r28_addr",  m_addr,  32'h80);
        m_ready = 1; m_rdata = 32'hFFFF0000;
        tick(1);
        m_ready = 0;
        check_eq("r28_done",  p_done,  1);
        check_eq("r28_rdata", p_rdata, 32'h1234);
        tick(1);
        p_req = 0;
        tick(1);

        // External read, then an external read that times out.
        e_req = 1; e_we = 0; e_addr = 32'h100; m_ready = 1; m_rdata = 32'hDEADBEEF;
        tick(1);
        tick(1);
        check_eq("r30_pre_done",  e_done,  1);
        check_eq("r30_pre_rdata", e_rdata, 32'hDEADBEEF);
        tick(1);
        m_ready = 0; e_addr = 32'h104;
        cnt = 0; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick(1);
            if (m_cs) cnt++;
            if (e_done) seen = 1;
        end
        check_eq("r30_seen",  seen,    1);
        check_eq("r30_cycles", cnt,    TIMEOUT);
        check_eq("r30_rdata", e_rdata, 0);
        check_eq("r30_err",   err,     1);
        e_req = 0;
        tick(1);
        p_req = 1; p_we = 0; m_ready = 1; m_rdata = 32'h55;
        tick(1);
        tick(1);
        tick(1);
        check_eq("r30_err_kept", err, 1);
        p_req = 0; m_ready = 0;
        tick(1);

        // Reset in the middle of a pipeline access.
        p_req = 1; p_we = 0; p_addr = 32'h200;
        tick(1);
        check_eq("r31_acc", m_cs, 1);
        reset = 1;
        tick(1);
        reset = 0; p_req = 0;
        check_eq("r31_cs",    m_cs,    0);
        check_eq("r31_busy",  busy,    0);
        check_eq("r31_err",   err,     0);
        check_eq("r31_rdata", p_rdata, 0);
        check_eq("r31_done",  p_done,  0);
        m_ready = 1;
        tick(1);
        check_eq("r31_nodone", p_done, 0);
        m_ready = 0;
        tick(1);

        // Both requesters saturated: four pipeline accesses per external one.
        do_reset(1);
        p_req = 1; e_req = 1; m_ready = 1;
        pcount = 0; ecount = 0;
        for (int i = 0; i < 45; i++) begin
            p_we = 1'($urandom); e_we = 1'($urandom); m_rdata = $urandom;
            tick(1);
            if (p_done) pcount++;
            if (e_done) begin
                check_eq("r29_pcount", pcount, EXT_MAX_WAIT);
                pcount = 0;
                ecount++;
            end
        end
        check_eq("r29_ecount", ecount, 3);
        p_req = 0; e_req = 0; m_ready = 0;
        tick(1);

        // Randomized traffic obeying the hold-until-done protocol.
        p_pend = 0; e_pend = 0;
        for (int c = 0; c < 2400; c++) begin
            case ((c / 600) % 4)
                0: pct = 60;
                1: pct = 5;
                2: pct = 90;
                default: pct = 30;
            endcase
            pd = exp_p_done();
            ed = exp_e_done();
            reset = ($urandom % 250 == 0);
            if (!p_pend && !(md_active && !md_ext)) begin
                p_req = ($urandom % 3 == 0); p_pend = p_req;
            end else if (p_pend && md_active && !md_ext && !md_finish && $urandom % 40 == 0) begin
                p_req = 0; p_pend = 0;
            end
            if (!e_pend && !(md_active && md_ext)) begin
                e_req = ($urandom % 4 == 0); e_pend = e_req;
            end else if (e_pend && md_active && md_ext && !md_finish && $urandom % 40 == 0) begin
                e_req = 0; e_pend = 0;
            end
            p_we = 1'($urandom); p_addr = $urandom; p_wdata = $urandom;
            p_sc = 2'($urandom); p_lc = 3'($urandom);
            e_we = 1'($urandom); e_addr = $urandom; e_wdata = $urandom;
            m_ready = ($urandom % 100 < pct); m_rdata = $urandom;
            tick(1);
            if (pd) p_pend = 0;
            if (ed) e_pend = 0;
            if (reset) begin
                p_pend = 0; e_pend = 0; p_req = 0; e_req = 0;
            end
        end
        reset = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter EXT_MAX_WAIT, default 4: max consecutive pipeline grants while ext request pending.
REQ-002 SHALL have parameter TIMEOUT, default 15: max cycles in an access state without m_ready.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port p_req  input  1  pipeline MEM-stage memory access request (CS); held until p_done.
REQ-006 SHALL have ports p_we  input  1  write enable; p_addr  input  32  address; p_wdata  input  32  store data; p_sc  input  2  store size code; p_lc  input  3  load size code.
REQ-007 SHALL have ports p_stall  output  1  pipeline freeze; p_done  output  1  completion pulse; p_rdata  output  32  load data.
REQ-008 SHALL have ports e_req, e_we  input  1; e_addr, e_wdata  input  32  external (loader/debug) requester, word access only.
REQ-009 SHALL have ports e_grant  output  1  ext access in progress; e_done  output  1  pulse; e_rdata  output  32.
REQ-010 SHALL have ports m_cs, m_w, m_r  output  1; m_addr, m_wdata  output  32; m_sc  output  2; m_lc  output  3  data memory port.
REQ-011 SHALL have ports m_rdata  input  32; m_ready  input  1  memory completion.
REQ-012 SHALL have ports busy  output  1  state != IDLE; err  output  1  sticky timeout flag.

Function
REQ-013 SHALL implement FSM states IDLE, P_ACC, E_ACC, P_DONE, E_DONE.
REQ-014 IDLE: p_req only -> P_ACC; e_req only -> E_ACC; both -> P_ACC unless win_cnt == EXT_MAX_WAIT, then E_ACC; neither -> IDLE.
REQ-015 On leaving IDLE, SHALL latch winner's we/addr/wdata/sc/lc; ext latches sc=0, lc=0 (word).
REQ-016 win_cnt SHALL increment on a pipeline grant while e_req=1 (saturating at EXT_MAX_WAIT), clear to 0 on any ext grant, hold otherwise.
REQ-017 In P_ACC/E_ACC: m_cs=1, m_w=latched we, m_r=!latched we, m_addr/m_sc/m_lc latched, m_wdata=latched wdata if write else 0; all m_* = 0 in other states.
REQ-018 x_ACC with m_ready=1 -> x_DONE; on that edge capture m_rdata into p_rdata/e_rdata if read (writes leave rdata unchanged).
REQ-019 p_done=1 exactly in P_DONE, e_done=1 exactly in E_DONE; x_DONE -> IDLE unconditionally; requests ignored in x_DONE.
REQ-020 p_stall SHALL be combinational: p_req && !p_done.
REQ-021 e_grant=1 in E_ACC and E_DONE.
REQ-022 Latency: request in IDLE cycle N -> m_cs at N+1; m_ready at cycle M -> done at M+1; min 3 cycles per access.
REQ-023 Access-cycle counter SHALL clear on entering x_ACC; if TIMEOUT cycles pass without m_ready -> x_DONE, rdata loaded 0, err set to 1.
REQ-024 err SHALL remain 1 until reset; arbitration continues normally after timeout.
REQ-025 Request dropped during x_ACC SHALL NOT abort the access (protocol violation, completes as latched).

Reset
REQ-026 reset SHALL force IDLE, win_cnt=0, cycle counter=0, err=0, p_rdata=e_rdata=0, all m_*, done, grant, busy outputs 0, including mid-access.

Verification
REQ-027 p_req read addr 0x40, m_ready 2 cycles after m_cs, m_rdata 0x1234 -> m_cs cycles N+1..N+3, p_done at N+4, p_rdata=0x1234, p_stall low at N+4.
REQ-028 p_req write addr 0x80 wdata 0xA5A5A5A5 sc=1 -> m_w=1, m_r=0, m_sc=1, m_wdata=0xA5A5A5A5, p_rdata unchanged.
REQ-029 p_req and e_req held continuously, m_ready immediate -> four pipeline accesses then one ext access (e_grant), win_cnt back to 0, repeat.
REQ-030 m_ready held 0 on ext read -> after 15 access cycles e_done pulses, e_rdata=0, err=1 and stays 1 over next access.
REQ-031 reset asserted in P_ACC -> next cycle IDLE, m_cs=0, err=0, p_rdata=0, no p_done pulse.
